// File: rtl/fifo_rr_arbiter_if.sv
// Source-bank / destination handshake bundle for the round-robin drain scheduler.
interface fifo_rr_arbiter_if #(
  parameter int N_FIFO    = 4,
  parameter int WORD_SIZE = 6
);
  logic [N_FIFO-1:0]           src_empty;
  logic [N_FIFO*WORD_SIZE-1:0] src_data;
  logic                        dst_almost_full;
  logic                        dst_full;
  logic [N_FIFO-1:0]           fifo_rd;
  logic [WORD_SIZE-1:0]        dst_data;
  logic                        dst_wr;

  // Scheduler side: consumes flags and data, issues pops and pushes.
  modport master (
    input  src_empty, src_data, dst_almost_full, dst_full,
    output fifo_rd, dst_data, dst_wr
  );

  // FIFO bank / destination side.
  modport slave (
    output src_empty, src_data, dst_almost_full, dst_full,
    input  fifo_rd, dst_data, dst_wr
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler draining N_FIFO source FIFOs into one destination FIFO.
// Owns the threshold registers, issues one-hot pops, pushes one cycle later.
module fifo_rr_arbiter #(
  parameter int N_FIFO    = 4,
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [PTR_L-1:0] empty_thr_in,
  input  logic [PTR_L-1:0] full_thr_in,
  fifo_rr_arbiter_if.master bus,
  output logic [PTR_L-1:0] empty_threshold,
  output logic [PTR_L-1:0] full_threshold,
  output logic [2:0]       state,
  output logic             idle,
  output logic             error
);
  localparam int RRW = (N_FIFO > 1) ? $clog2(N_FIFO) : 1;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [RRW-1:0]   rr_q, gidx_q;
  logic             pending_q;
  logic [PTR_L-1:0] ethr_q, fthr_q;

  logic [N_FIFO-1:0]                elig, rd;
  logic [RRW-1:0]                   grant, idx;
  logic                             any_g;
  logic                             wr;
  logic [N_FIFO-1:0][WORD_SIZE-1:0] src_w;

  assign src_w = bus.src_data;

  // Rotating priority scan from rr_q; pops are held while a reload is requested
  // so an in-flight push can finish before returning to INIT.
  always_comb begin
    elig  = '0;
    if (state_q == S_ACTIVE && !init && !bus.dst_almost_full) elig = ~bus.src_empty;
    grant = '0;
    any_g = 1'b0;
    idx   = '0;
    for (int k = N_FIFO-1; k >= 0; k--) begin
      idx = rr_q + RRW'(k);
      if (elig[idx]) begin
        grant = idx;
        any_g = 1'b1;
      end
    end
    rd = '0;
    if (any_g) rd[grant] = 1'b1;
  end

  assign wr           = pending_q && (state_q != S_ERROR);
  assign bus.fifo_rd  = rd;
  assign bus.dst_wr   = wr;
  assign bus.dst_data = pending_q ? src_w[gidx_q] : '0;

  // Next state; an overflowing push overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE:   if (init && !pending_q)         state_d = S_INIT;
                else if (!(&bus.src_empty))     state_d = S_ACTIVE;
      S_ACTIVE: if (init && !pending_q)         state_d = S_INIT;
                else if ((&bus.src_empty) && !pending_q) state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
    if (wr && bus.dst_full) state_d = S_ERROR;
  end

  // State, pointer, push pipeline and threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      rr_q      <= '0;
      gidx_q    <= '0;
      pending_q <= 1'b0;
      ethr_q    <= PTR_L'(1);
      fthr_q    <= PTR_L'(MEM_SIZE-1);
    end else begin
      state_q   <= state_d;
      pending_q <= |rd;
      gidx_q    <= grant;
      if (any_g) rr_q <= grant + RRW'(1);
      if (state_q == S_INIT) begin
        ethr_q <= empty_thr_in;
        fthr_q <= full_thr_in;
      end
    end
  end

  assign empty_threshold = ethr_q;
  assign full_threshold  = fthr_q;
  assign state           = state_q;
  assign idle            = (state_q == S_IDLE);
  assign error           = (state_q == S_ERROR);
endmodule
